// File: rtl/regfile_2r1w.sv
// Parametrised 2-read / 1-write register bank for the CPU datapath.
// Optional hardwired-zero R0, write-to-read bypass and registered read ports.

module regfile_2r1w_rport #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  input  logic                         wr_commit,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         re,
  input  logic [ADDR_W-1:0]            raddr,
  output logic [WIDTH-1:0]             rdata
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic             in_range;
  logic [WIDTH-1:0] rv;

  assign in_range = {1'b0, raddr} < DEPTH_L;

  // Out-of-range and hardwired-zero reads never touch the array, so no X leaks out.
  always_comb begin
    rv = '0;
    if (in_range && !((ZERO_R0 != 0) && (raddr == '0))) begin
      if ((BYPASS != 0) && wr_commit && (waddr == raddr)) rv = wdata;
      else                                                rv = mem[raddr];
    end
  end

  logic unused_bp;
  assign unused_bp = &{1'b0, wr_commit, waddr, wdata};

  if (READ_REG != 0) begin : g_reg
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = rv;
    end

    always_ff @(posedge clk) begin
      if (!rst) rdata_q <= '0;
      else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end else begin : g_comb
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, re};
    assign rdata     = rv;
  end
endmodule

module regfile_2r1w #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              wr_ack
);
  localparam int           NUM_RP  = 2;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         wr_ack_q, wr_ack_d;
  logic                         wr_commit;
  logic [NUM_RP-1:0]            re_v;
  logic [NUM_RP-1:0][ADDR_W-1:0] raddr_v;
  logic [NUM_RP-1:0][WIDTH-1:0] rdata_v;

  assign wr_commit = we && ({1'b0, waddr} < DEPTH_L) &&
                     !((ZERO_R0 != 0) && (waddr == '0));

  always_comb begin
    mem_d    = mem_q;
    wr_ack_d = wr_commit;
    if (wr_commit) mem_d[waddr] = wdata;
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign wr_ack  = wr_ack_q;
  assign re_v    = {re_b, re_a};
  assign raddr_v = {raddr_b, raddr_a};

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
    regfile_2r1w_rport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .ZERO_R0(ZERO_R0), .BYPASS(BYPASS), .READ_REG(READ_REG)
    ) u_rport (
      .clk       (clk),
      .rst       (rst),
      .mem       (mem_q),
      .wr_commit (wr_commit),
      .waddr     (waddr),
      .wdata     (wdata),
      .re        (re_v[p]),
      .raddr     (raddr_v[p]),
      .rdata     (rdata_v[p])
    );
  end

  assign rdata_a = rdata_v[0];
  assign rdata_b = rdata_v[1];
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised general-purpose register bank for the CPU datapath.
- Holds DEPTH words of WIDTH bits, with one synchronous write port and two independent read ports (A and B), which feed the ALU operand muxes.
- Optional features: hardwired-zero R0, write-to-read bypass, and registered (1-cycle) reads for timing closure.
- Replaces discrete single-word enable registers in the datapath.

Parameters:
- WIDTH, 16: data width of every register and data port.
- DEPTH, 8: number of registers. Legal range 2..2**ADDR_W.
- ADDR_W, 3: width of all address ports. Must satisfy 2**ADDR_W >= DEPTH.
- ZERO_R0, 1: 1 means register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: 1 means a read of the address being written in the same cycle returns wdata.
- READ_REG, 0: 0 means combinational read ports. 1 means read data is registered, with 1-cycle latency.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- re_a  in  1  read enable for port A. Used only when READ_REG=1.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  WIDTH  read data, port A.
- re_b  in  1  read enable for port B. Used only when READ_REG=1.
- raddr_b  in  ADDR_W  read address, port B.
- rdata_b  out  WIDTH  read data, port B.
- wr_ack  out  1  registered; high for the one cycle after a write that was actually committed.

Behaviour:
- Reset
  - Reset is synchronous and active-low: when rst is sampled low on a rising edge of clk, all registers are cleared to 0.
  - The same edge clears the rdata_a/rdata_b output registers (READ_REG=1) and wr_ack.
  - Reset has priority over a coincident write; that write is lost.
  - Reset asserted mid-sequence: the register contents visible in the following cycle are 0.
- Write
  - A write commits on the rising edge where rst=1, we=1, waddr<DEPTH, and not (ZERO_R0=1 and waddr=0).
  - wr_ack=1 in the cycle after a committed write, otherwise 0.
  - A write to an address >= DEPTH is silently dropped, and wr_ack stays 0.
- Read value function, rv(addr)
  - 0 if addr >= DEPTH.
  - 0 if ZERO_R0=1 and addr=0.
  - wdata if BYPASS=1 and the write-commit condition holds for the same cycle with waddr=addr.
  - Otherwise the stored word.
- READ_REG=0
  - rdata_x = rv(raddr_x) combinationally, in the same cycle.
  - With BYPASS=0, a same-cycle read of the address being written returns the old value; the new value is visible from the next cycle.
- READ_REG=1
  - On each edge with rst=1 and re_x=1, rdata_x <= rv(raddr_x), so data appears 1 cycle after the address.
  - With re_x=0, rdata_x holds its value.
  - With BYPASS=1, a read issued in the write cycle captures the new data. With BYPASS=0 it captures the old data.
- Port independence
  - Ports A and B are fully independent and may read the same address simultaneously.
  - Both ports may hit the bypass in the same cycle; both then return wdata.
- Width rule: no truncation or extension; all data paths are exactly WIDTH bits.
- No X propagation: out-of-range and unwritten reads return 0.

Test Plan:
- Default parameters, rst low for 2 cycles, then high; read all 8 addresses on A and B -> every rdata = 0x0000 and wr_ack = 0.
- Write R3=0x1234, then R5=0xBEEF; next cycle raddr_a=3, raddr_b=5 -> rdata_a=0x1234, rdata_b=0xBEEF, and wr_ack pulses once per write.
- Write R0=0xFFFF with ZERO_R0=1, then read R0 -> 0x0000 and wr_ack stays 0. Rebuild with ZERO_R0=0 -> 0xFFFF.
- Same-cycle write R2=0xA5A5 with raddr_a=raddr_b=2 (old value 0x0001)
  - BYPASS=1 -> both ports read 0xA5A5 in that cycle.
  - BYPASS=0 -> both read 0x0001 in that cycle, then 0xA5A5 in the next.
- READ_REG=1: set raddr_a=3 with re_a=1 at cycle N -> rdata_a updates at N+1. Then drop re_a and change raddr_a -> rdata_a holds.
- DEPTH=6, ADDR_W=3: write addr 7 = 0x5555, then read addr 7 -> 0x0000 and wr_ack=0. Then pulse rst low in the same cycle as a write R1=0x00FF -> R1 reads 0x0000 afterwards.
